seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider (one quotient bit per cycle).
// Latency from the accepted start edge to done is WIDTH+3 cycles, or 1 cycle
// for a zero divisor. Define SEQ_DIVIDER_SIGNED_EN for two's-complement
// operands (truncating quotient, remainder signed like the dividend);
// otherwise operands are unsigned and INIT/FIX are pass-through cycles.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] div_hi,
  output logic             divby0flag
);

  localparam int unsigned CNT_W = WIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   dvd_q,   dvd_d;
  logic [WIDTH-1:0]   dvs_q,   dvs_d;
  logic [WIDTH-1:0]   rem_q,   rem_d;
  logic [WIDTH-1:0]   quo_q,   quo_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic               flag_q,  flag_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract divisor.
  logic [WIDTH:0]     shifted_c;
  logic [WIDTH:0]     diff_c;
  assign shifted_c = {rem_q, quo_q[WIDTH-1]};
  assign diff_c    = shifted_c - {1'b0, dvs_q};

  assign busy       = busy_q;
  assign done       = done_q;
  assign div_lo     = lo_q;
  assign div_hi     = hi_q;
  assign divby0flag = flag_q;

  // State and datapath registers; reset overrides everything, including start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      flag_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      flag_q    <= flag_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    flag_d    = flag_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor == '0) begin
            // Zero divisor: report immediately, keep the previous result.
            flag_d  = 1'b1;
            state_d = DONE;
          end else begin
            flag_d  = 1'b0;
            state_d = INIT;
          end
        end
      end

      INIT: begin
        rem_d = '0;
        cnt_d = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
        neg_rem_d = dvd_q[WIDTH-1];
        quo_d     = dvd_q[WIDTH-1] ? (~dvd_q + WIDTH'(1)) : dvd_q;
        dvs_d     = dvs_q[WIDTH-1] ? (~dvs_q + WIDTH'(1)) : dvs_q;
`else
        quo_d     = dvd_q;
`endif
        state_d = RUN;
      end

      RUN: begin
        if (!diff_c[WIDTH]) begin
          rem_d = diff_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_c[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        lo_d = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        hi_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
`else
        lo_d = quo_q;
        hi_d = rem_q;
`endif
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule
